xif_mem_responder: RTL and testbench

- Core-side responder for the CV-X-IF memory request/response and memory result interfaces.
- Accepts load/store requests issued by the FPU subsystem (flw/fsw and narrower variants) and checks alignment.
- Executes each request as one OBI data-bus transaction.
- Returns the load data or bus error on the memory result interface; lives in the example core next to the LSU.

---
 rtl/xif_mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_xif_mem_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : xif_mem_responder                                             |
// | Purpose  : Core-side responder for CV-X-IF memory request/result. Takes  |
// |            one coprocessor load/store at a time, runs it as a single     |
// |            OBI data-bus transaction and returns a one-cycle result.      |
// | Ports    : clk_i, rst_ni            clock / async active-low reset        |
// |            x_mem_valid_i/ready_o    request handshake                     |
// |            x_mem_req_*_i            id, addr, we, size, wdata             |
// |            x_mem_resp_exc*_o        misalignment exception (handshake)   |
// |            x_mem_result_*_o         result pulse: valid, id, rdata, err   |
// |            data_*                   OBI master (req/gnt, rvalid/rdata)    |
// | Options  : XIF_MEM_MISALIGN_EXC_EN - when defined, misaligned requests    |
// |            are rejected with an exception; otherwise they are issued     |
// |            with the low address bits forced to zero.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module xif_mem_responder #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_MEM_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   x_mem_valid_i,
    output logic                   x_mem_ready_o,
    input  logic [X_ID_WIDTH-1:0]  x_mem_req_id_i,
    input  logic [X_MEM_WIDTH-1:0] x_mem_req_addr_i,
    input  logic                   x_mem_req_we_i,
    input  logic [1:0]             x_mem_req_size_i,
    input  logic [X_MEM_WIDTH-1:0] x_mem_req_wdata_i,
    output logic                   x_mem_resp_exc_o,
    output logic [5:0]             x_mem_resp_exccode_o,
    output logic                   x_mem_result_valid_o,
    output logic [X_ID_WIDTH-1:0]  x_mem_result_id_o,
    output logic [X_MEM_WIDTH-1:0] x_mem_result_rdata_o,
    output logic                   x_mem_result_err_o,
    output logic                   data_req_o,
    input  logic                   data_gnt_i,
    output logic [X_MEM_WIDTH-1:0] data_addr_o,
    output logic                   data_we_o,
    output logic [3:0]             data_be_o,
    output logic [X_MEM_WIDTH-1:0] data_wdata_o,
    input  logic                   data_rvalid_i,
    input  logic [X_MEM_WIDTH-1:0] data_rdata_i,
    input  logic                   data_err_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OBI_REQ = 2'd1,
        OBI_RSP = 2'd2,
        RESULT  = 2'd3
    } state_t;

    state_t state, next_state;

    // Latched request / response
    logic [X_ID_WIDTH-1:0]  req_id;
    logic [X_MEM_WIDTH-3:0] req_waddr;
    logic [1:0]             req_off;
    logic                   req_we;
    logic [1:0]             req_size;
    logic [X_MEM_WIDTH-1:0] req_wdata;
    logic [X_MEM_WIDTH-1:0] rsp_rdata;
    logic                   rsp_err;

    // Request decode
    logic       misaligned;
    logic       accept;
    logic       exc;
    logic [5:0] exccode;
    logic [1:0] eff_size;
    logic [1:0] eff_off;
    logic       handshake;

    always_comb begin
        misaligned = (x_mem_req_size_i == 2'b01 && x_mem_req_addr_i[0]) ||
                     (x_mem_req_size_i == 2'b10 && x_mem_req_addr_i[1:0] != 2'b00) ||
                     (x_mem_req_size_i == 2'b11);
`ifdef XIF_MEM_MISALIGN_EXC_EN
        accept   = !misaligned;
        exc      = (state == IDLE) && x_mem_valid_i && misaligned;
        exccode  = exc ? (x_mem_req_we_i ? 6'd6 : 6'd4) : 6'd0;
        eff_size = x_mem_req_size_i;
        eff_off  = x_mem_req_addr_i[1:0];
`else
        // Misaligned accesses are silently aligned down; reserved size acts as word.
        accept   = 1'b1;
        exc      = 1'b0;
        exccode  = 6'd0;
        eff_size = (x_mem_req_size_i == 2'b11) ? 2'b10 : x_mem_req_size_i;
        eff_off  = misaligned ? 2'b00 : x_mem_req_addr_i[1:0];
`endif
    end

    assign handshake = (state == IDLE) && x_mem_valid_i;

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (handshake && accept) next_state = OBI_REQ;
            OBI_REQ: if (data_gnt_i)          next_state = OBI_RSP;
            OBI_RSP: if (data_rvalid_i)       next_state = RESULT;
            RESULT:                           next_state = IDLE;
            default:                          next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Byte enables, lane-replicated write data and right-aligned read data
    logic [3:0]             be;
    logic [X_MEM_WIDTH-1:0] wdata_lanes;
    logic [X_MEM_WIDTH-1:0] rdata_shifted;
    logic [X_MEM_WIDTH-1:0] rdata_masked;

    always_comb begin
        case (req_size)
            2'b00: begin
                be          = 4'b0001 << req_off;
                wdata_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be          = 4'b0011 << req_off;
                wdata_lanes = {2{req_wdata[15:0]}};
            end
            default: begin
                be          = 4'b1111;
                wdata_lanes = req_wdata;
            end
        endcase
        rdata_shifted = data_rdata_i >> {req_off, 3'b000};
        case (req_size)
            2'b00:   rdata_masked = {24'd0, rdata_shifted[7:0]};
            2'b01:   rdata_masked = {16'd0, rdata_shifted[15:0]};
            default: rdata_masked = rdata_shifted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_id    <= '0;
            req_waddr <= '0;
            req_off   <= '0;
            req_we    <= 1'b0;
            req_size  <= '0;
            req_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (handshake && accept) begin
                req_id    <= x_mem_req_id_i;
                req_waddr <= x_mem_req_addr_i[X_MEM_WIDTH-1:2];
                req_off   <= eff_off;
                req_we    <= x_mem_req_we_i;
                req_size  <= eff_size;
                req_wdata <= x_mem_req_wdata_i;
            end
            if (state == OBI_RSP && data_rvalid_i) begin
                rsp_rdata <= req_we ? '0 : rdata_masked;
                rsp_err   <= data_err_i;
            end
        end
    end

    // Outputs are gated by state so nothing leaks outside its phase.
    assign x_mem_ready_o        = (state == IDLE);
    assign x_mem_resp_exc_o     = exc;
    assign x_mem_resp_exccode_o = exccode;

    assign data_req_o   = (state == OBI_REQ);
    assign data_addr_o  = data_req_o ? {req_waddr, 2'b00} : '0;
    assign data_we_o    = data_req_o & req_we;
    assign data_be_o    = data_req_o ? be : 4'b0000;
    assign data_wdata_o = (data_req_o && req_we) ? wdata_lanes : '0;

    assign x_mem_result_valid_o = (state == RESULT);
    assign x_mem_result_id_o    = x_mem_result_valid_o ? req_id : '0;
    assign x_mem_result_rdata_o = x_mem_result_valid_o ? rsp_rdata : '0;
    assign x_mem_result_err_o   = x_mem_result_valid_o & rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_xif_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_xif_mem_responder                                          |
// | Purpose  : Directed self-checking bench for xif_mem_responder.           |
// | Options  : XIF_MEM_MISALIGN_EXC_EN selects the expected misaligned       |
// |            behaviour, matching the DUT build.                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_xif_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        x_mem_valid_i;
    logic        x_mem_ready_o;
    logic [3:0]  x_mem_req_id_i;
    logic [31:0] x_mem_req_addr_i;
    logic        x_mem_req_we_i;
    logic [1:0]  x_mem_req_size_i;
    logic [31:0] x_mem_req_wdata_i;
    logic        x_mem_resp_exc_o;
    logic [5:0]  x_mem_resp_exccode_o;
    logic        x_mem_result_valid_o;
    logic [3:0]  x_mem_result_id_o;
    logic [31:0] x_mem_result_rdata_o;
    logic        x_mem_result_err_o;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    xif_mem_responder #(.X_ID_WIDTH(4), .X_MEM_WIDTH(32)) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .x_mem_valid_i        (x_mem_valid_i),
        .x_mem_ready_o        (x_mem_ready_o),
        .x_mem_req_id_i       (x_mem_req_id_i),
        .x_mem_req_addr_i     (x_mem_req_addr_i),
        .x_mem_req_we_i       (x_mem_req_we_i),
        .x_mem_req_size_i     (x_mem_req_size_i),
        .x_mem_req_wdata_i    (x_mem_req_wdata_i),
        .x_mem_resp_exc_o     (x_mem_resp_exc_o),
        .x_mem_resp_exccode_o (x_mem_resp_exccode_o),
        .x_mem_result_valid_o (x_mem_result_valid_o),
        .x_mem_result_id_o    (x_mem_result_id_o),
        .x_mem_result_rdata_o (x_mem_result_rdata_o),
        .x_mem_result_err_o   (x_mem_result_err_o),
        .data_req_o           (data_req_o),
        .data_gnt_i           (data_gnt_i),
        .data_addr_o          (data_addr_o),
        .data_we_o            (data_we_o),
        .data_be_o            (data_be_o),
        .data_wdata_o         (data_wdata_o),
        .data_rvalid_i        (data_rvalid_i),
        .data_rdata_i         (data_rdata_i),
        .data_err_i           (data_err_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One full transaction: handshake, optional grant wait, response, result.
    task automatic run_txn(input logic [3:0] id, input logic [31:0] addr, input logic we,
                           input logic [1:0] size, input logic [31:0] wdata, input int gnt_dly,
                           input logic [31:0] rd, input logic er,
                           input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        x_mem_valid_i     = 1'b1;
        x_mem_req_id_i    = id;
        x_mem_req_addr_i  = addr;
        x_mem_req_we_i    = we;
        x_mem_req_size_i  = size;
        x_mem_req_wdata_i = wdata;
        #1;
        chk("hs_ready", {31'd0, x_mem_ready_o}, 32'd1);
        chk("hs_exc",   {31'd0, x_mem_resp_exc_o}, 32'd0);
        tick();
        x_mem_valid_i = 1'b0;
        for (int i = 0; i < gnt_dly; i++) begin
            #1;
            chk("wait_req",   {31'd0, data_req_o}, 32'd1);
            chk("wait_addr",  data_addr_o, e_addr);
            chk("wait_ready", {31'd0, x_mem_ready_o}, 32'd0);
            tick();
        end
        data_gnt_i = 1'b1;
        #1;
        chk("req",   {31'd0, data_req_o}, 32'd1);
        chk("addr",  data_addr_o, e_addr);
        chk("be",    {28'd0, data_be_o}, {28'd0, e_be});
        chk("we",    {31'd0, data_we_o}, {31'd0, we});
        if (we) chk("wdata", data_wdata_o, e_wdata);
        chk("req_ready", {31'd0, x_mem_ready_o}, 32'd0);
        tick();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = rd;
        data_err_i    = er;
        #1;
        chk("rsp_req_low", {31'd0, data_req_o}, 32'd0);
        chk("rsp_no_res",  {31'd0, x_mem_result_valid_o}, 32'd0);
        tick();
        data_rvalid_i = 1'b0;
        data_err_i    = 1'b0;
        #1;
        chk("res_valid", {31'd0, x_mem_result_valid_o}, 32'd1);
        chk("res_id",    {28'd0, x_mem_result_id_o}, {28'd0, id});
        chk("res_rdata", x_mem_result_rdata_o, e_rdata);
        chk("res_err",   {31'd0, x_mem_result_err_o}, {31'd0, er});
        chk("res_ready", {31'd0, x_mem_ready_o}, 32'd0);
        tick();
        #1;
        chk("post_valid", {31'd0, x_mem_result_valid_o}, 32'd0);
        chk("post_ready", {31'd0, x_mem_ready_o}, 32'd1);
    endtask

    initial begin
        rst_ni            = 1'b0;
        x_mem_valid_i     = 1'b0;
        x_mem_req_id_i    = '0;
        x_mem_req_addr_i  = '0;
        x_mem_req_we_i    = 1'b0;
        x_mem_req_size_i  = '0;
        x_mem_req_wdata_i = '0;
        data_gnt_i        = 1'b0;
        data_rvalid_i     = 1'b0;
        data_rdata_i      = '0;
        data_err_i        = 1'b0;

        tick();
        #1;
        chk("rst_ready", {31'd0, x_mem_ready_o}, 32'd1);
        chk("rst_req",   {31'd0, data_req_o}, 32'd0);
        chk("rst_res",   {31'd0, x_mem_result_valid_o}, 32'd0);
        chk("rst_exc",   {31'd0, x_mem_resp_exc_o}, 32'd0);
        chk("rst_addr",  data_addr_o, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // Word load, minimum latency
        run_txn(4'd3, 32'h0000_0100, 1'b0, 2'b10, 32'h0, 0, 32'hDEAD_BEEF, 1'b0,
                32'h0000_0100, 4'b1111, 32'h0, 32'hDEAD_BEEF);
        // Byte store to lane 3: replicated data, read data ignored
        run_txn(4'd5, 32'h0000_0203, 1'b1, 2'b00, 32'h0000_005A, 0, 32'h1234_5678, 1'b0,
                32'h0000_0200, 4'b1000, 32'h5A5A_5A5A, 32'h0);
        // Half load from upper half
        run_txn(4'd7, 32'h0000_0302, 1'b0, 2'b01, 32'h0, 0, 32'hABCD_1234, 1'b0,
                32'h0000_0300, 4'b1100, 32'h0, 32'h0000_ABCD);
        // Byte load from lane 1
        run_txn(4'd1, 32'h0000_0101, 1'b0, 2'b00, 32'h0, 0, 32'hAABB_CCDD, 1'b0,
                32'h0000_0100, 4'b0010, 32'h0, 32'h0000_00CC);
        // Half store to upper half
        run_txn(4'd9, 32'h0000_0102, 1'b1, 2'b01, 32'hFFFF_1234, 0, 32'h0, 1'b0,
                32'h0000_0100, 4'b1100, 32'h1234_1234, 32'h0);
        // Grant held off 5 cycles, bus error returned
        run_txn(4'd12, 32'h0000_0040, 1'b0, 2'b10, 32'h0, 5, 32'h1111_1111, 1'b1,
                32'h0000_0040, 4'b1111, 32'h0, 32'h1111_1111);

`ifdef XIF_MEM_MISALIGN_EXC_EN
        // Misaligned word store: exception in handshake cycle, no bus activity
        x_mem_valid_i     = 1'b1;
        x_mem_req_id_i    = 4'd2;
        x_mem_req_addr_i  = 32'h0000_0105;
        x_mem_req_we_i    = 1'b1;
        x_mem_req_size_i  = 2'b10;
        x_mem_req_wdata_i = 32'h0;
        #1;
        chk("mis_st_exc",  {31'd0, x_mem_resp_exc_o}, 32'd1);
        chk("mis_st_code", {26'd0, x_mem_resp_exccode_o}, 32'd6);
        tick();
        x_mem_req_addr_i = 32'h0000_0301;
        x_mem_req_we_i   = 1'b0;
        x_mem_req_size_i = 2'b01;
        #1;
        chk("mis_ld_exc",  {31'd0, x_mem_resp_exc_o}, 32'd1);
        chk("mis_ld_code", {26'd0, x_mem_resp_exccode_o}, 32'd4);
        chk("mis_req",     {31'd0, data_req_o}, 32'd0);
        tick();
        x_mem_valid_i = 1'b0;
        #1;
        chk("mis_exc_clr", {31'd0, x_mem_resp_exc_o}, 32'd0);
        chk("mis_req2",    {31'd0, data_req_o}, 32'd0);
        chk("mis_ready",   {31'd0, x_mem_ready_o}, 32'd1);
        tick();
        #1;
        chk("mis_req3",    {31'd0, data_req_o}, 32'd0);
`else
        // Misaligned accesses are aligned down; reserved size behaves as word
        run_txn(4'd2, 32'h0000_0105, 1'b1, 2'b10, 32'hCAFE_F00D, 0, 32'h0, 1'b0,
                32'h0000_0104, 4'b1111, 32'hCAFE_F00D, 32'h0);
        run_txn(4'd4, 32'h0000_0301, 1'b0, 2'b01, 32'h0, 0, 32'h8765_4321, 1'b0,
                32'h0000_0300, 4'b0011, 32'h0, 32'h0000_4321);
        run_txn(4'd6, 32'h0000_0203, 1'b0, 2'b11, 32'h0, 0, 32'h0102_0304, 1'b0,
                32'h0000_0200, 4'b1111, 32'h0, 32'h0102_0304);
`endif

        // Reset while waiting for the response abandons the transaction
        x_mem_valid_i    = 1'b1;
        x_mem_req_id_i   = 4'd8;
        x_mem_req_addr_i = 32'h0000_0500;
        x_mem_req_we_i   = 1'b0;
        x_mem_req_size_i = 2'b10;
        tick();
        x_mem_valid_i = 1'b0;
        data_gnt_i    = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        rst_ni     = 1'b0;
        #1;
        chk("arst_ready", {31'd0, x_mem_ready_o}, 32'd1);
        chk("arst_req",   {31'd0, data_req_o}, 32'd0);
        chk("arst_res",   {31'd0, x_mem_result_valid_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h5555_AAAA;
        tick();
        data_rvalid_i = 1'b0;
        #1;
        chk("stray_res",   {31'd0, x_mem_result_valid_o}, 32'd0);
        chk("stray_ready", {31'd0, x_mem_ready_o}, 32'd1);
        tick();
        #1;
        chk("stray_res2",  {31'd0, x_mem_result_valid_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
